// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Define DCACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module dcache_wt #(
  parameter int DATA_WIDTH = 32,
  parameter int SETS = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic [2:0]            cpu_funct3,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);
  localparam int IW = $clog2(SETS);
  localparam int TW = ADDR_WIDTH - 2 - IW;
  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;
  state_t state, state_n;
  logic [SETS-1:0] valid;
  logic [TW-1:0] tags [SETS];
  logic [DATA_WIDTH-1:0] lines [SETS];
  logic [IW-1:0] idx, widx;
  logic [TW-1:0] tag, wtag;
  logic [DATA_WIDTH-1:0] word, ext, merged;
  logic [7:0] b;
  logic [15:0] h;
  logic hit, whit, ld_hit, st_ok;
  assign idx = cpu_addr[IW+1:2];
  assign tag = cpu_addr[ADDR_WIDTH-1:IW+2];
  // the transaction in flight is addressed by the latched mem_addr, not the live CPU inputs
  assign widx = mem_addr[IW+1:2];
  assign wtag = mem_addr[ADDR_WIDTH-1:IW+2];
  assign word = lines[idx];
  assign hit = valid[idx] && tags[idx] == tag;
  assign whit = valid[widx] && tags[widx] == wtag;
  assign ld_hit = state == IDLE && cpu_req && !cpu_we && hit;
  assign st_ok = !cpu_funct3[2] && cpu_funct3[1:0] != 2'b11;
  assign b = word[{cpu_addr[1:0], 3'b000} +: 8];
  assign h = word[{cpu_addr[1], 4'b0000} +: 16];
  always_comb begin
    ext = cpu_funct3 == 3'b000 ? {{(DATA_WIDTH-8){b[7]}}, b} :
          cpu_funct3 == 3'b001 ? {{(DATA_WIDTH-16){h[15]}}, h} :
          cpu_funct3 == 3'b010 ? word :
          cpu_funct3 == 3'b100 ? {{(DATA_WIDTH-8){1'b0}}, b} :
          cpu_funct3 == 3'b101 ? {{(DATA_WIDTH-16){1'b0}}, h} : '0;
    cpu_rdata = ld_hit ? ext : '0;
  end
  always_comb begin
    merged = lines[widx];
    if (mem_funct3 == 3'b000)
      merged[{mem_addr[1:0], 3'b000} +: 8] = mem_wdata[7:0];
    else if (mem_funct3 == 3'b001)
      merged[{mem_addr[1], 4'b0000} +: 16] = mem_wdata[15:0];
    else
      merged = mem_wdata;
  end
  always_comb begin
    state_n = state;
    cpu_stall = 1'b0;
    case (state)
      IDLE: if (cpu_req && (cpu_we ? st_ok : !hit)) begin
        cpu_stall = 1'b1;
        state_n = cpu_we ? WRITE : FILL;
      end
      FILL: begin
        cpu_stall = 1'b1;
        state_n = mem_ack ? IDLE : FILL;
      end
      WRITE: begin
        cpu_stall = !mem_ack;
        state_n = mem_ack ? IDLE : WRITE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      valid <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_funct3 <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && state_n != IDLE) begin
        mem_req <= 1'b1;
        mem_we <= cpu_we;
        mem_addr <= cpu_we ? cpu_addr : {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
        mem_wdata <= cpu_we ? cpu_wdata : '0;
        mem_funct3 <= cpu_we ? cpu_funct3 : 3'b010;
      end else if (mem_req && mem_ack) begin
        mem_req <= 1'b0;
      end
      if (state == FILL && mem_ack)
        valid[widx] <= 1'b1;
    end
  end
  // tag/data need no reset: valid gates every use of them
  always_ff @(posedge clk) begin
    if (!rst && state == FILL && mem_ack) begin
      tags[widx] <= wtag;
      lines[widx] <= mem_rdata;
    end else if (!rst && state == WRITE && mem_ack && whit) begin
      lines[widx] <= merged;
    end
  end
`ifdef DCACHE_STATS_EN
  logic replay;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      replay <= 1'b0;
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      replay <= state == FILL && mem_ack;
      if (ld_hit && !replay && hit_count != '1)
        hit_count <= hit_count + 32'd1;
      if (state == IDLE && state_n == FILL && miss_count != '1)
        miss_count <= miss_count + 32'd1;
    end
  end
`endif
endmodule
